// File: rtl/ice_bus_pkg.sv
// Shared definitions for the ICE byte-bus response path.
// Contents: framer state encoding, frame geometry constants, common
// response type bytes and a helper that clamps a FIFO count to the
// largest payload length a single frame can announce.
package ice_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_TYPE = 3'd2,
        ST_ID   = 3'd3,
        ST_LEN  = 3'd4,
        ST_PYLD = 3'd5,
        ST_DONE = 3'd6
    } frm_state_e;

    localparam int ICE_HDR_BYTES = 3;
    localparam int ICE_MAX_PYLD  = 255;

    localparam logic [7:0] ICE_TYPE_ACK  = 8'h41;
    localparam logic [7:0] ICE_TYPE_NAK  = 8'h4E;
    localparam logic [7:0] ICE_TYPE_DATA = 8'h64;

    // The length byte is 8 bits wide, so a deeper buffer is announced as 255.
    function automatic logic [7:0] sat_len(input logic [8:0] cnt);
        return (cnt > 9'(ICE_MAX_PYLD)) ? 8'(ICE_MAX_PYLD) : cnt[7:0];
    endfunction

endpackage

// File: rtl/ice_bus_resp_framer_if.sv
// Handshake/bus bundle of the ICE response framer.
// Groups: payload write port (pl_*), frame request handshake (resp_*),
// status (busy) and the slave arbitration channel (sl_*).
// Modports: slave = the framer, master = whatever drives it
// (device logic plus bus controller).
interface ice_bus_resp_framer_if #(
    parameter int CNT_W = 7
);
    logic [7:0]       pl_data;
    logic             pl_wr;
    logic             pl_full;
    logic [CNT_W-1:0] pl_count;
    logic             resp_valid;
    logic             resp_ready;
    logic [7:0]       resp_type;
    logic [7:0]       resp_evt_id;
    logic             busy;
    logic             sl_arb_request;
    logic             sl_arb_grant;
    logic [7:0]       sl_data;
    logic             sl_data_latch;

    modport slave (
        input  pl_data, pl_wr, resp_valid, resp_type, resp_evt_id,
               sl_arb_grant, sl_data_latch,
        output pl_full, pl_count, resp_ready, busy, sl_arb_request, sl_data
    );

    modport master (
        output pl_data, pl_wr, resp_valid, resp_type, resp_evt_id,
               sl_arb_grant, sl_data_latch,
        input  pl_full, pl_count, resp_ready, busy, sl_arb_request, sl_data
    );
endinterface

// File: rtl/ice_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
// Ports: clk, rst (synchronous, active-low), wr/wr_data (write, ignored
// when full), rd (pop, ignored when empty), data_out (current head),
// count (bytes held), full, empty.
// DEPTH must be a power of two >= 2 so the pointers wrap for free.
module ice_byte_fifo #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [7:0]       wr_data,
    input  logic             rd,
    output logic [7:0]       data_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        // Write and pop together leave the count unchanged.
        if (wr_en && !rd_en) count_d = count_q + CNT_W'(1);
        if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign data_out = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/ice_bus_resp_framer.sv
// ICE slave response framer.
// Buffers payload bytes, and on a frame request streams
// type, evt_id, len, payload over the slave arbitration channel.
// Ports: clk, rst (synchronous, active-low), bus (slave modport):
//   pl_data/pl_wr/pl_full/pl_count   payload buffer write side
//   resp_valid/resp_ready            frame request handshake
//   resp_type/resp_evt_id            header fields latched at acceptance
//   busy                             frame in progress
//   sl_arb_request/sl_arb_grant/sl_data/sl_data_latch  byte channel
//
// state | meaning
// IDLE  | ready for a request, bus released
// REQ   | requesting bus ownership, waiting for grant
// TYPE  | presenting the type byte
// ID    | presenting the event id
// LEN   | presenting the snapshotted payload length
// PYLD  | presenting the FIFO head, one pop per latch
// DONE  | request dropped for one cycle so the arbiter can re-arbitrate
module ice_bus_resp_framer
    import ice_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 7
) (
    input logic                  clk,
    input logic                  rst,
    ice_bus_resp_framer_if.slave bus
);
    frm_state_e       state_q, state_d;
    logic [7:0]       type_q, type_d;
    logic [7:0]       evt_q, evt_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sent_q, sent_d;

    logic             adv;
    logic             pop;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       cnt_ext;

    logic             req_o;
    logic [7:0]       data_o;
    logic             ready_o;

    // A latch only counts while the arbiter actually grants us the bus.
    assign adv     = bus.sl_arb_grant && bus.sl_data_latch;
    assign pop     = adv && (state_q == ST_PYLD) && !fifo_empty;
    assign cnt_ext = 9'(fifo_count);

    ice_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr       (bus.pl_wr),
        .wr_data  (bus.pl_data),
        .rd       (pop),
        .data_out (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            type_q  <= '0;
            evt_q   <= '0;
            len_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            evt_q   <= evt_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        evt_d   = evt_q;
        len_d   = len_q;
        sent_d  = sent_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.resp_valid) begin
                    // Length is frozen here; later writes wait for the next frame.
                    type_d  = bus.resp_type;
                    evt_d   = bus.resp_evt_id;
                    len_d   = sat_len(cnt_ext);
                    sent_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.sl_arb_grant) state_d = ST_TYPE;
            end
            ST_TYPE: begin
                if (adv) state_d = ST_ID;
            end
            ST_ID: begin
                if (adv) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (adv) state_d = (len_q == 8'd0) ? ST_DONE : ST_PYLD;
            end
            ST_PYLD: begin
                if (adv) begin
                    sent_d = sent_q + 8'd1;
                    if (sent_q + 8'd1 == len_q) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_o   = 1'b0;
        data_o  = 8'h00;
        ready_o = 1'b0;
        unique case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_REQ:  req_o   = 1'b1;
            ST_TYPE: begin
                req_o  = 1'b1;
                data_o = type_q;
            end
            ST_ID: begin
                req_o  = 1'b1;
                data_o = evt_q;
            end
            ST_LEN: begin
                req_o  = 1'b1;
                data_o = len_q;
            end
            ST_PYLD: begin
                req_o  = 1'b1;
                data_o = fifo_head;
            end
            ST_DONE: req_o = 1'b0;
            default: req_o = 1'b0;
        endcase
    end

    assign bus.sl_arb_request = req_o;
    assign bus.sl_data        = data_o;
    assign bus.resp_ready     = ready_o;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.pl_count       = fifo_count;
    assign bus.pl_full        = fifo_full;

endmodule

// File: tb/tb_ice_bus_resp_framer.sv
// Testbench for ice_bus_resp_framer.
// Stimulus drives inputs 1 time unit after the rising edge; the bus agent
// (arbiter + controller model) drives grant/latch and checks every consumed
// byte on the falling edge against a scoreboard of expected frame bytes.
module tb_ice_bus_resp_framer;
    import ice_bus_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ice_bus_resp_framer_if #(.CNT_W(7)) bus ();

    ice_bus_resp_framer #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] b;
        bit         last;
        bit         pl;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    int         inflight = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    bit grant_en = 1'b1;
    int grant_pct = 100;
    int latch_pct = 100;
    int latch_period = 1;
    int stop_at = 1000;
    int frame_cnt = 0;
    int post_cnt = 0;
    int cyc = 0;

    bit         owned = 1'b0;
    bit         req_s = 1'b0;
    bit         grant_s = 1'b0;
    bit         latch_s = 1'b0;
    bit         rst_s = 1'b0;
    bit         prev_data_state = 1'b0;
    logic [7:0] data_s = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp_v);
    endtask

    // Bus agent / monitor.
    always @(negedge clk) begin
        logic       cur_req;
        logic [7:0] cur_data;
        bit         g;
        bit         l;
        bit         cur_data_state;
        exp_t       e;
        cyc++;
        // Ownership as seen by the controller: a granted request edge moves
        // the framer past REQ; a released request ends the frame.
        if (!rst_s) owned = 1'b0;
        else if (req_s && grant_s) owned = 1'b1;
        else if (!req_s) owned = 1'b0;

        cur_req  = bus.sl_arb_request;
        cur_data = bus.sl_data;
        cur_data_state = owned && cur_req;

        if (prev_data_state && rst_s && !latch_s) begin
            check("req_hold", {31'd0, cur_req}, 32'd1);
            if (cur_req) check("data_stable", {24'd0, cur_data}, {24'd0, data_s});
        end

        if (post_cnt == 1) begin
            check("req_low_after_last", {31'd0, cur_req}, 32'd0);
            check("ready_in_done", {31'd0, bus.resp_ready}, 32'd0);
            post_cnt = 2;
        end else if (post_cnt == 2) begin
            check("ready_back", {31'd0, bus.resp_ready}, 32'd1);
            check("busy_clear", {31'd0, bus.busy}, 32'd0);
            check("idle_data", {24'd0, cur_data}, 32'd0);
            post_cnt = 0;
        end

        g = rst && grant_en && cur_req && ($urandom_range(99) < grant_pct);
        l = g && cur_data_state && (cyc % latch_period == 0)
            && ($urandom_range(99) < latch_pct) && (frame_cnt < stop_at);

        if (l) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {24'd0, cur_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("frame_byte", {24'd0, cur_data}, {24'd0, e.b});
                frame_cnt++;
                if (e.pl) inflight--;
                if (e.last) begin
                    frame_cnt = 0;
                    post_cnt = 1;
                end
            end
        end

        bus.sl_arb_grant  = g;
        bus.sl_data_latch = l;
        req_s   = cur_req;
        grant_s = g;
        latch_s = l;
        rst_s   = rst;
        data_s  = cur_data;
        prev_data_state = cur_data_state;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.pl_wr   = 1'b1;
        bus.pl_data = d;
        tick();
        bus.pl_wr   = 1'b0;
        if (model_q.size() + inflight < DEPTH) model_q.push_back(d);
    endtask

    task automatic check_count(input string name);
        check(name, 32'(bus.pl_count), 32'(model_q.size()));
        check("pl_full", {31'd0, bus.pl_full}, {31'd0, model_q.size() >= DEPTH});
    endtask

    // Reference: a frame is header (type, id, min(count,255)) followed by the
    // oldest buffered bytes, which then leave the model buffer.
    task automatic send_frame(input logic [7:0] t, input logic [7:0] id);
        int   n;
        int   tries;
        exp_t e;
        tries = 0;
        while (!bus.resp_ready && tries < 3000) begin
            tick();
            tries++;
        end
        if (!bus.resp_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        check("req_before_accept", {31'd0, bus.sl_arb_request}, 32'd0);
        bus.resp_valid  = 1'b1;
        bus.resp_type   = t;
        bus.resp_evt_id = id;
        tick();
        bus.resp_valid  = 1'b0;
        n = (model_q.size() > ICE_MAX_PYLD) ? ICE_MAX_PYLD : model_q.size();
        e.pl = 1'b0; e.last = 1'b0;
        e.b = t;       exp_q.push_back(e);
        e.b = id;      exp_q.push_back(e);
        e.b = 8'(n);   e.last = (n == 0); exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.b = model_q.pop_front();
            e.pl = 1'b1;
            e.last = (i == n - 1);
            exp_q.push_back(e);
            inflight++;
        end
        check("req_after_accept", {31'd0, bus.sl_arb_request}, 32'd1);
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        check("ready_after_accept", {31'd0, bus.resp_ready}, 32'd0);
    endtask

    task automatic wait_done();
        int tries;
        tries = 0;
        while (!(exp_q.size() == 0 && post_cnt == 0 && bus.resp_ready) && tries < 5000) begin
            tick();
            tries++;
        end
        if (tries >= 5000) check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_frame_cnt(input int target);
        int tries;
        tries = 0;
        while (frame_cnt < target && tries < 3000) begin
            tick();
            tries++;
        end
        if (frame_cnt < target) check("progress_timeout", 32'(frame_cnt), 32'(target));
    endtask

    task automatic check_reset_state();
        check("rst_req", {31'd0, bus.sl_arb_request}, 32'd0);
        check("rst_data", {24'd0, bus.sl_data}, 32'd0);
        check("rst_ready", {31'd0, bus.resp_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_count", 32'(bus.pl_count), 32'd0);
        check("rst_full", {31'd0, bus.pl_full}, 32'd0);
    endtask

    initial begin
        logic [7:0] types [3];
        int         n;
        types[0] = ICE_TYPE_ACK;
        types[1] = ICE_TYPE_NAK;
        types[2] = ICE_TYPE_DATA;

        bus.pl_data = 8'h00;
        bus.pl_wr = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_type = 8'h00;
        bus.resp_evt_id = 8'h00;
        bus.sl_arb_grant = 1'b0;
        bus.sl_data_latch = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check_reset_state();
        rst = 1'b1;
        tick();

        // Basic frame.
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        check_count("count_3");
        send_frame(8'h64, 8'h05);
        wait_done();
        check("count_after_basic", 32'(bus.pl_count), 32'd0);

        // Zero-length frame.
        send_frame(8'h41, 8'h07);
        wait_done();
        check("count_after_zero", 32'(bus.pl_count), 32'd0);

        // Stalls: late grant, sparse latches, grant drop mid-payload.
        for (int i = 0; i < 6; i++) write_byte(8'($urandom));
        grant_en = 1'b0;
        send_frame(ICE_TYPE_DATA, 8'h21);
        repeat (10) tick();
        grant_en = 1'b1;
        latch_period = 3;
        wait_frame_cnt(5);
        grant_en = 1'b0;
        repeat (4) tick();
        grant_en = 1'b1;
        wait_done();
        latch_period = 1;

        // Overflow.
        for (int i = 1; i <= 70; i++) begin
            write_byte(8'(i));
            check_count("count_fill");
        end
        send_frame(ICE_TYPE_DATA, 8'h30);
        wait_done();
        check("count_after_overflow", 32'(bus.pl_count), 32'd0);

        // Reset after the 2nd payload latch of a 5-byte frame.
        for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i));
        stop_at = 5;
        send_frame(ICE_TYPE_DATA, 8'h44);
        wait_frame_cnt(5);
        rst = 1'b0;
        tick();
        check_reset_state();
        exp_q.delete();
        model_q.delete();
        inflight = 0;
        frame_cnt = 0;
        post_cnt = 0;
        stop_at = 1000;
        rst = 1'b1;
        tick();
        write_byte(8'h5A);
        write_byte(8'hA5);
        send_frame(ICE_TYPE_ACK, 8'h45);
        wait_done();

        // Writes during transmission belong to the next frame.
        write_byte(8'h01);
        write_byte(8'h02);
        latch_period = 2;
        send_frame(ICE_TYPE_DATA, 8'h50);
        wait_frame_cnt(3);
        write_byte(8'hAA);
        wait_done();
        check("count_after_midwrite", 32'(bus.pl_count), 32'd1);
        latch_period = 1;
        send_frame(ICE_TYPE_DATA, 8'h51);
        wait_done();
        check("count_after_aa", 32'(bus.pl_count), 32'd0);

        // Randomized frames with random arbiter/controller behaviour.
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(20);
            for (int i = 0; i < n; i++) write_byte(8'($urandom));
            check_count("count_rand");
            grant_pct = $urandom_range(100, 50);
            latch_pct = $urandom_range(100, 40);
            send_frame(types[$urandom_range(2)], 8'($urandom));
            wait_done();
            check_count("count_rand_after");
        end
        grant_pct = 100;
        latch_pct = 100;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ice_bus_resp_framer.md
Name: ice_bus_resp_framer

Overview:
- Slave-side response transmitter for the ICE master/slave byte bus.
- Packages a response frame and streams it over the slave arbitration channel: sl_arb_request, sl_arb_grant, sl_data, sl_data_latch.
- Frame format: type, evt_id, len, then payload. This is the same format the bus controller parses on its receive side.
- Instantiated once per device. The bus controller's priority arbiter forwards the bytes to the UART.

Parameters:
- FIFO_DEPTH, 64: payload buffer depth in bytes. Power of 2, at most 256.
- CNT_W, 7: width of the count. Equals log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- pl_data  in  8  payload byte to buffer.
- pl_wr  in  1  write pl_data into the payload FIFO.
- pl_full  out  1  FIFO full.
- pl_count  out  CNT_W  bytes currently buffered.
- resp_valid  in  1  request to send a frame.
- resp_ready  out  1  framer idle; a request can be accepted.
- resp_type  in  8  first frame byte (e.g. 0x64 'd', 0x4E 'N').
- resp_evt_id  in  8  event id echoed in the frame.
- busy  out  1  frame in progress (not IDLE).
- sl_arb_request  out  1  request for bus ownership.
- sl_arb_grant  in  1  ownership granted by the arbiter.
- sl_data  out  8  current outgoing byte.
- sl_data_latch  in  1  controller consumed sl_data this cycle.

Behaviour:
- Reset values: sl_arb_request=0, sl_data=0x00, resp_ready=1, busy=0, pl_count=0, pl_full=0. FIFO pointers are cleared.
- FIFO:
  - pl_wr while pl_full: write ignored, contents unchanged.
  - Simultaneous write and pop: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, REQ, TYPE, ID, LEN, PYLD, DONE.
- IDLE:
  - resp_ready=1, sl_data=0x00.
  - On resp_valid, latch resp_type, resp_evt_id and len=min(pl_count,255), then go to REQ.
- REQ:
  - sl_arb_request=1.
  - When sl_arb_grant=1, go to TYPE in the same edge.
- TYPE/ID/LEN/PYLD:
  - sl_arb_request=1.
  - sl_data is combinational from state: type, evt_id, len, FIFO head.
  - State advances only on the edge where sl_data_latch=1. Without a latch, sl_data holds stable for any number of cycles.
  - sl_data_latch is honoured only while sl_arb_grant=1. If grant drops mid-frame, hold state and keep requesting.
  - LEN with len=0: go to DONE. Otherwise go to PYLD.
  - PYLD: each latch pops one FIFO byte and increments an 8-bit sent counter. When the latch makes sent==len, go to DONE.
- DONE:
  - sl_arb_request=0 for exactly one cycle so the arbiter can re-arbitrate. Then go to IDLE.
- Timing:
  - Accept edge N: sl_arb_request first high in cycle N+1.
  - After the last latch, request is low in the next cycle.
  - resp_ready returns 1 two cycles after the last latch.
- The frame length is snapshotted at acceptance. Bytes written during transmission stay buffered for the next frame.
- resp_valid outside IDLE is ignored; no queueing.
- Reset mid-frame: on the next edge go to IDLE, drop sl_arb_request, flush the FIFO. No partial byte is reissued.
- busy = (state != IDLE).

Decomposition:
- Shared package ice_bus_pkg holds:
  - state encoding;
  - ICE_HDR_BYTES=3;
  - ICE_MAX_PYLD=255;
  - common type bytes (ACK 0x41, NAK 0x4E, data 0x64).
- One sub-module: ice_byte_fifo. It is a synchronous FIFO, parameterised on depth, with wr, rd, data_out, count, full and empty; same clk/rst convention.
- The framer FSM lives in the top module.

Test Plan:
- Basic frame: write 0x11,0x22,0x33; resp_type=0x64, evt_id=0x05; grant and latch every cycle -> sl_data sequence 0x64,0x05,0x03,0x11,0x22,0x33. Request low the cycle after the 6th latch; resp_ready=1 one cycle later; pl_count=0.
- Zero-length frame: empty FIFO, type 0x41, evt 0x07 -> exactly 3 bytes 0x41,0x07,0x00; no FIFO pop.
- Stalls: grant delayed 10 cycles; latch pulses every 3rd cycle; grant dropped for 4 cycles mid-payload -> sl_data stable between latches, request stays 1, byte sequence intact.
- Overflow: write 70 bytes with depth 64 -> pl_full after 64 writes, last 6 dropped; frame len=0x40; bytes 1..64 in order.
- Reset mid-frame: rst=0 after the 2nd payload latch of a 5-byte frame -> next cycle request=0, sl_data=0x00, pl_count=0, resp_ready=1. A following frame is correct.
- Writes during send: 2 bytes buffered, accept, then write 0xAA during PYLD -> frame len=0x02; after DONE pl_count=1; next frame carries 0xAA.
